// File: rtl/vita_frame_recorder.sv
// Frame recorder: packs accepted camera lane samples into OUT_W words and
// frames them with sof/eof, counting frames and lines per frame.
module vita_frame_recorder #(
  parameter int NCH    = 4,
  parameter int PIX_W  = 8,
  parameter int OUT_W  = 64,
  parameter int LINE_W = 11
) (
  input  logic                 par_clock,
  input  logic                 par_reset_n,
  input  logic [NCH*PIX_W-1:0] cam_d,
  input  logic                 FS,
  input  logic                 FE,
  input  logic                 LS,
  input  logic                 IMG,
  input  logic                 INV,
  input  logic                 arm,
  input  logic                 continuous,
  output logic                 we,
  output logic [OUT_W-1:0]     pixels,
  output logic                 sof,
  output logic                 eof,
  output logic [15:0]          frame_count,
  output logic [LINE_W-1:0]    line_count,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int SMP_W = NCH * PIX_W;
  localparam int RATIO = OUT_W / SMP_W;
  localparam int K_W   = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [K_W-1:0] LAST_SLOT = K_W'(RATIO - 1);

  // state   | meaning
  // IDLE    | waiting for arm or continuous
  // ARMED   | waiting for FS
  // CAPTURE | packing samples of the current frame
  // ABORT   | invalid sync seen, output suppressed until FE
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_ABORT} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [K_W-1:0]      r_slot;
  logic [OUT_W-1:0]    r_pack;
  logic                r_sof_pend;
  logic                r_we;
  logic                r_sof;
  logic                r_eof;
  logic [OUT_W-1:0]    r_pixels;
  logic [15:0]         r_frame_cnt;
  logic [LINE_W-1:0]   r_line_cnt;
  logic                r_frame_err;

  logic                w_accept;
  logic                w_fs_arm;
  logic                w_restart;
  logic                w_fe_cap;
  logic                w_abort;
  logic [K_W-1:0]      w_slot_base;
  logic [OUT_W-1:0]    w_packed;
  logic                w_slot_full;
  logic                w_emit;
  logic                w_sof_pend;

  always_ff @(posedge par_clock or negedge par_reset_n) begin
    if (!par_reset_n) r_state <= S_IDLE;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_fs_arm    = 1'b0;
    w_restart   = 1'b0;
    w_fe_cap    = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (arm || continuous) w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (FS) begin
          w_state_nxt = S_CAPTURE;
          w_fs_arm    = 1'b1;
          w_accept    = IMG;
        end
      end
      S_CAPTURE: begin
        if (INV) begin
          w_state_nxt = S_ABORT;
          w_abort     = 1'b1;
        end else if (FE) begin
          w_state_nxt = continuous ? S_ARMED : S_IDLE;
          w_fe_cap    = 1'b1;
          w_accept    = IMG;
        end else begin
          w_accept  = IMG;
          w_restart = FS;
        end
      end
      S_ABORT: begin
        if (FE) w_state_nxt = continuous ? S_ARMED : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A restarting FS drops the partial word and lands its sample in slot 0.
  always_comb begin
    w_slot_base = w_restart ? '0 : r_slot;
    w_packed    = w_restart ? '0 : r_pack;
    if (w_accept) w_packed[int'(w_slot_base)*SMP_W +: SMP_W] = cam_d;
  end

  assign w_slot_full = w_accept && (w_slot_base == LAST_SLOT);
  assign w_emit      = w_slot_full || w_fe_cap;
  assign w_sof_pend  = (w_fs_arm || w_restart) ? 1'b1 : r_sof_pend;

  always_ff @(posedge par_clock or negedge par_reset_n) begin
    if (!par_reset_n) begin
      r_slot      <= '0;
      r_pack      <= '0;
      r_sof_pend  <= 1'b0;
      r_we        <= 1'b0;
      r_sof       <= 1'b0;
      r_eof       <= 1'b0;
      r_pixels    <= '0;
      r_frame_cnt <= '0;
      r_line_cnt  <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_we  <= w_emit;
      r_sof <= w_emit && w_sof_pend;
      r_eof <= w_fe_cap;
      if (w_emit) r_pixels <= w_packed;

      // The FE flush word already carries any remainder, so the packer empties.
      if (w_emit || w_abort) begin
        r_pack <= '0;
        r_slot <= '0;
      end else begin
        r_pack <= w_packed;
        r_slot <= w_accept ? (w_slot_base + K_W'(1)) : w_slot_base;
      end
      r_sof_pend <= w_emit ? 1'b0 : w_sof_pend;

      if (w_fe_cap) r_frame_cnt <= r_frame_cnt + 16'd1;

      if (w_fs_arm || w_restart)
        r_line_cnt <= '0;
      else if (r_state == S_CAPTURE && LS && (r_line_cnt != '1))
        r_line_cnt <= r_line_cnt + LINE_W'(1);

      if (w_abort || w_restart) r_frame_err <= 1'b1;
      else if (w_fs_arm)        r_frame_err <= 1'b0;
    end
  end

  assign we          = r_we;
  assign pixels      = r_pixels;
  assign sof         = r_sof;
  assign eof         = r_eof;
  assign frame_count = r_frame_cnt;
  assign line_count  = r_line_cnt;
  assign frame_err   = r_frame_err;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_vita_frame_recorder.sv
// Bench for vita_frame_recorder: default build plus a 2-lane 10-bit build
// driven with the same control stream, checked against a frame-level model.
module tb_vita_frame_recorder;

  localparam int WA = 32, RA = 2;
  localparam int WB = 20, RB = 2;
  typedef logic [65:0] wrd_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] cam_a;
  logic [19:0] cam_b;
  logic fs, fe, ls, img, inv, arm, cont;

  logic we_a, sof_a, eof_a, ferr_a, busy_a;
  logic [63:0] pix_a;
  logic [15:0] fc_a;
  logic [10:0] lc_a;
  logic we_b, sof_b, eof_b, ferr_b, busy_b;
  logic [39:0] pix_b;
  logic [15:0] fc_b;
  logic [10:0] lc_b;

  int total = 0;
  int bad = 0;
  int fc_exp = 0;
  bit fe_took;
  logic [31:0] dir_q[$];
  logic [31:0] sa[$];
  logic [19:0] sb[$];
  wrd_t got_a[$];
  wrd_t got_b[$];

  always #5 clk = ~clk;

  vita_frame_recorder #(.NCH(4), .PIX_W(8), .OUT_W(64), .LINE_W(11)) dut_a (
    .par_clock(clk), .par_reset_n(rst_n), .cam_d(cam_a),
    .FS(fs), .FE(fe), .LS(ls), .IMG(img), .INV(inv), .arm(arm), .continuous(cont),
    .we(we_a), .pixels(pix_a), .sof(sof_a), .eof(eof_a), .frame_count(fc_a),
    .line_count(lc_a), .frame_err(ferr_a), .busy(busy_a));

  vita_frame_recorder #(.NCH(2), .PIX_W(10), .OUT_W(40), .LINE_W(11)) dut_b (
    .par_clock(clk), .par_reset_n(rst_n), .cam_d(cam_b),
    .FS(fs), .FE(fe), .LS(ls), .IMG(img), .INV(inv), .arm(arm), .continuous(cont),
    .we(we_b), .pixels(pix_b), .sof(sof_b), .eof(eof_b), .frame_count(fc_b),
    .line_count(lc_b), .frame_err(ferr_b), .busy(busy_b));

  always @(negedge clk) begin
    if (we_a) got_a.push_back({sof_a, eof_a, pix_a});
    if (we_b) got_b.push_back({sof_b, eof_b, 24'b0, pix_b});
  end

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit f_s, input bit f_e, input bit l_s, input bit im,
                      input bit iv, input bit take);
    logic [31:0] da;
    logic [31:0] db;
    @(negedge clk);
    da = $urandom;
    if (im && dir_q.size() > 0) da = dir_q.pop_front();
    db = $urandom;
    cam_a = da;
    cam_b = db[19:0];
    fs = f_s; fe = f_e; ls = l_s; img = im; inv = iv; arm = 1'b0;
    if (take) begin
      sa.push_back(da);
      sb.push_back(db[19:0]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic arm_pulse();
    @(negedge clk);
    fs = 0; fe = 0; ls = 0; img = 0; inv = 0; arm = 1'b1;
  endtask

  task automatic begin_frame();
    sa.delete(); sb.delete(); got_a.delete(); got_b.delete();
    fe_took = 1'b0;
  endtask

  // FS cycle, nimg IMG cycles (random gaps, LS on the first nls), then FE.
  task automatic frame(input int nimg, input int nls, input bit fe_img);
    begin_frame();
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < nimg; i++) begin
      if ($urandom_range(0, 3) == 0) step(0, 0, 0, 0, 0, 0);
      step(0, 0, (i < nls), 1, 0, 1);
    end
    step(0, 1, 0, fe_img, 0, fe_img);
    fe_took = fe_img;
    idle(3);
  endtask

  // Full groups of RATIO samples become words; FE adds a flush word holding
  // the padded remainder unless its own sample completed the last group.
  task automatic check_words(input string tag);
    int nw;
    wrd_t e;
    nw = sa.size() / RA;
    if ((sa.size() % RA) != 0 || !fe_took) nw++;
    chk({tag, "_cnt_a"}, 66'(got_a.size()), 66'(nw));
    for (int i = 0; i < nw; i++) begin
      e = '0;
      e[65] = (i == 0);
      e[64] = (i == nw - 1);
      for (int j = 0; j < RA; j++)
        if (i * RA + j < sa.size()) e[j*WA +: WA] = sa[i*RA+j];
      chk({tag, "_word_a"}, (i < got_a.size()) ? got_a[i] : 'x, e);
    end
    nw = sb.size() / RB;
    if ((sb.size() % RB) != 0 || !fe_took) nw++;
    chk({tag, "_cnt_b"}, 66'(got_b.size()), 66'(nw));
    for (int i = 0; i < nw; i++) begin
      e = '0;
      e[65] = (i == 0);
      e[64] = (i == nw - 1);
      for (int j = 0; j < RB; j++)
        if (i * RB + j < sb.size()) e[j*WB +: WB] = sb[i*RB+j];
      chk({tag, "_word_b"}, (i < got_b.size()) ? got_b[i] : 'x, e);
    end
  endtask

  task automatic chk_status(input string tag, input int lc, input bit ferr, input bit bsy);
    chk({tag, "_fc_a"}, 66'(fc_a), 66'(fc_exp & 16'hFFFF));
    chk({tag, "_fc_b"}, 66'(fc_b), 66'(fc_exp & 16'hFFFF));
    chk({tag, "_lc_a"}, 66'(lc_a), 66'(lc));
    chk({tag, "_lc_b"}, 66'(lc_b), 66'(lc));
    chk({tag, "_ferr"}, {ferr_a, ferr_b}, {ferr, ferr});
    chk({tag, "_busy"}, {busy_a, busy_b}, {bsy, bsy});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, l;
    rst_n = 1'b0;
    cam_a = '0; cam_b = '0;
    fs = 0; fe = 0; ls = 0; img = 0; inv = 0; arm = 0; cont = 0;
    repeat (2) @(negedge clk);
    chk("rst_out_a", {we_a, sof_a, eof_a, pix_a}, '0);
    chk("rst_out_b", {we_b, sof_b, eof_b, pix_b}, '0);
    chk_status("rst", 0, 0, 0);
    rst_n = 1'b1;
    idle(2);

    // Directed four-sample frame, FE carries the fourth sample.
    dir_q = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    arm_pulse();
    frame(3, 0, 1);
    chk("dir4_w0", got_a[0], {1'b1, 1'b0, 64'h0706050403020100});
    chk("dir4_w1", got_a[1], {1'b0, 1'b1, 64'h0F0E0D0C0B0A0908});
    check_words("dir4");
    fc_exp++;
    chk_status("dir4", 0, 0, 0);

    // Three samples then a separate FE: zero-padded partial flush.
    dir_q = '{32'h03020100, 32'h07060504, 32'h0B0A0908};
    arm_pulse();
    frame(3, 1, 0);
    chk("dir3_w1", got_a[1], {1'b0, 1'b1, 64'h000000000B0A0908});
    check_words("dir3");
    fc_exp++;
    chk_status("dir3", 1, 0, 0);

    // Empty frame: one all-zero word with sof and eof.
    arm_pulse();
    frame(0, 0, 0);
    check_words("empty");
    fc_exp++;
    chk_status("empty", 0, 0, 0);

    // Random single-shot frames.
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(0, 7);
      l = (n == 0) ? 0 : $urandom_range(0, n);
      arm_pulse();
      frame(n, l, $urandom_range(0, 1));
      check_words("rand");
      fc_exp++;
      chk_status("rand", l, 0, 0);
    end

    // arm outside IDLE is ignored: an extra pulse mid-frame changes nothing.
    arm_pulse();
    begin_frame();
    step(1, 0, 0, 1, 0, 1);
    arm_pulse();
    step(0, 1, 0, 0, 0, 0);
    idle(3);
    check_words("armig");
    fc_exp++;
    chk_status("armig", 0, 0, 0);

    // Continuous mode: three frames, two LS each.
    cont = 1'b1;
    idle(1);
    for (int k = 0; k < 3; k++) begin
      frame(4, 2, $urandom_range(0, 1));
      check_words("cont");
      fc_exp++;
      chk_status("cont", 2, 0, 1);
    end

    // Dropping continuous mid-frame takes effect at that frame's FE.
    begin_frame();
    step(1, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    cont = 1'b0;
    step(0, 0, 0, 1, 0, 1);
    chk("contoff_busy", busy_a, 1'b1);
    step(0, 1, 0, 0, 0, 0);
    idle(3);
    check_words("contoff");
    fc_exp++;
    chk_status("contoff", 0, 0, 0);

    // INV mid-frame: abort, no words, no frame count.
    arm_pulse();
    begin_frame();
    step(1, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    chk("abort_ferr", {ferr_a, ferr_b}, 2'b11);
    step(0, 1, 0, 1, 0, 0);
    idle(3);
    chk("abort_nw_a", 66'(got_a.size()), 66'd0);
    chk("abort_nw_b", 66'(got_b.size()), 66'd0);
    chk_status("abort", 0, 1, 0);

    // Next accepted FS clears frame_err.
    arm_pulse();
    begin_frame();
    step(1, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    chk("fsclr_ferr", {ferr_a, ferr_b}, 2'b00);
    step(0, 1, 0, 1, 0, 1);
    fe_took = 1'b1;
    idle(3);
    check_words("fsclr");
    fc_exp++;
    chk_status("fsclr", 0, 0, 0);

    // FS inside CAPTURE restarts the frame and flags an error.
    arm_pulse();
    begin_frame();
    step(1, 0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 0, 0);
    sa.delete(); sb.delete();
    step(1, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    step(0, 1, 0, 0, 0, 0);
    idle(3);
    check_words("restart");
    fc_exp++;
    chk_status("restart", 0, 1, 0);

    // Reset mid-word: everything clears at once.
    arm_pulse();
    begin_frame();
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    fc_exp = 0;
    chk("midrst_out_a", {we_a, sof_a, eof_a, pix_a}, '0);
    chk("midrst_out_b", {we_b, sof_b, eof_b, pix_b}, '0);
    chk_status("midrst", 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    arm_pulse();
    frame(3, 1, 0);
    check_words("postrst");
    fc_exp++;
    chk_status("postrst", 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
